// File: rtl/reaction_timer_fsm_pkg.sv
// Shared definitions for the reaction-time round controller: state encoding and default sizes.
package reaction_timer_fsm_pkg;

    localparam int unsigned TIME_W_DEF = 14;
    localparam int unsigned MAX_MS_DEF = 9999;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_TIMING = 3'd2,
        ST_RESULT = 3'd3,
        ST_FOUL   = 3'd4
    } state_t;

    // States from which a Start edge begins a new round.
    function automatic logic is_rest_state(input state_t s);
        return (s == ST_IDLE) || (s == ST_RESULT) || (s == ST_FOUL);
    endfunction

endpackage

// File: rtl/reaction_timer_fsm_rise_edge.sv
// 1-bit rising-edge detector: pulse when the current sample is high and the previous one was low.
module rise_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/reaction_timer_fsm.sv
// Round controller for the reaction-time game: arms the delay counter, times the player, flags fouls.
// Optional BEST_TIME_EN adds a BestTime output tracking the fastest completed round.
module reaction_timer_fsm
    import reaction_timer_fsm_pkg::*;
#(
    parameter int unsigned TIME_W = TIME_W_DEF,
    parameter int unsigned MAX_MS = MAX_MS_DEF
) (
    input  logic              ClockIn,
    input  logic              Reset,
    input  logic              Start,
    input  logic              React,
    input  logic              DelayDone,
    input  logic              TickMs,
    output logic              DelayEnable,
    output logic              Led,
    output logic [TIME_W-1:0] Time,
    output logic              Valid,
    output logic              FalseStart
`ifdef BEST_TIME_EN
    ,
    output logic [TIME_W-1:0] BestTime
`endif
);

    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_MS);

    logic start_rise;
    logic react_rise;

    rise_edge u_start_edge (
        .clk_i  (ClockIn),
        .rst_i  (Reset),
        .d_i    (Start),
        .rise_o (start_rise)
    );

    rise_edge u_react_edge (
        .clk_i  (ClockIn),
        .rst_i  (Reset),
        .d_i    (React),
        .rise_o (react_rise)
    );

    state_t            state_q, state_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              en_q, led_q, valid_q, foul_q;

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        case (state_q)
            ST_ARMED: begin
                if (react_rise) begin
                    state_d = ST_FOUL;
                end else if (DelayDone) begin
                    state_d = ST_TIMING;
                end
            end
            ST_TIMING: begin
                // A press wins over a coincident tick, so Time stays frozen on the press cycle.
                if (react_rise) begin
                    state_d = ST_RESULT;
                end else if (TickMs) begin
                    if (time_q >= MAX_T) begin
                        state_d = ST_RESULT;
                    end else begin
                        time_d = time_q + TIME_W'(1);
                    end
                end
            end
            default: begin
                if (is_rest_state(state_q) && start_rise) begin
                    state_d = ST_ARMED;
                    time_d  = '0;
                end else if (!is_rest_state(state_q)) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they change together with the state register.
    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            en_q    <= 1'b0;
            led_q   <= 1'b0;
            valid_q <= 1'b0;
            foul_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            en_q    <= (state_d == ST_ARMED);
            led_q   <= (state_d == ST_TIMING);
            valid_q <= (state_d == ST_RESULT);
            foul_q  <= (state_d == ST_FOUL);
        end
    end

    assign DelayEnable = en_q;
    assign Led         = led_q;
    assign Time        = time_q;
    assign Valid       = valid_q;
    assign FalseStart  = foul_q;

`ifdef BEST_TIME_EN
    logic [TIME_W-1:0] best_q, best_d;

    always_comb begin
        best_d = best_q;
        if ((state_q == ST_TIMING) && (state_d == ST_RESULT) && (time_d < best_q)) begin
            best_d = time_d;
        end
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            best_q <= MAX_T;
        end else begin
            best_q <= best_d;
        end
    end

    assign BestTime = best_q;
`endif

endmodule

// File: tb/tb_reaction_timer_fsm.sv
// Self-checking bench: two controllers (default and MAX_MS=5) against a round-level behavioural model.
module tb_reaction_timer_fsm;

    localparam int TW   = 14;
    localparam int MAXA = 9999;
    localparam int MAXB = 5;

    localparam int P_IDLE = 0, P_ARM = 1, P_TIM = 2, P_RES = 3, P_FOUL = 4;

    logic clk = 1'b0;
    logic rst = 1'b1, start = 1'b0, react = 1'b0, done = 1'b0, tick = 1'b0;

    logic          en_a, led_a, val_a, fs_a;
    logic [TW-1:0] tm_a;
    logic          en_b, led_b, val_b, fs_b;
    logic [TW-1:0] tm_b;
`ifdef BEST_TIME_EN
    logic [TW-1:0] best_a, best_b;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reaction_timer_fsm dut_a (
        .ClockIn(clk), .Reset(rst), .Start(start), .React(react),
        .DelayDone(done), .TickMs(tick),
        .DelayEnable(en_a), .Led(led_a), .Time(tm_a), .Valid(val_a), .FalseStart(fs_a)
`ifdef BEST_TIME_EN
        , .BestTime(best_a)
`endif
    );

    reaction_timer_fsm #(.MAX_MS(MAXB)) dut_b (
        .ClockIn(clk), .Reset(rst), .Start(start), .React(react),
        .DelayDone(done), .TickMs(tick),
        .DelayEnable(en_b), .Led(led_b), .Time(tm_b), .Valid(val_b), .FalseStart(fs_b)
`ifdef BEST_TIME_EN
        , .BestTime(best_b)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: round phase, elapsed ms and best time per instance.
    int   ph[2], mt[2], mb[2];
    logic ps = 1'b0, pr = 1'b0;
    bit   live = 1'b0;
    bit   se, re;

    function automatic int maxv(input int i);
        return (i == 0) ? MAXA : MAXB;
    endfunction

    always @(posedge clk) begin
        se = start && !ps;
        re = react && !pr;
        if (rst) begin
            live = 1'b1;
            ps = 1'b0;
            pr = 1'b0;
            for (int i = 0; i < 2; i++) begin
                ph[i] = P_IDLE; mt[i] = 0; mb[i] = maxv(i);
            end
        end else if (live) begin
            ps = start;
            pr = react;
            for (int i = 0; i < 2; i++) begin
                case (ph[i])
                    P_ARM: begin
                        if (re) ph[i] = P_FOUL;
                        else if (done) ph[i] = P_TIM;
                    end
                    P_TIM: begin
                        if (re) begin
                            ph[i] = P_RES;
                            if (mt[i] < mb[i]) mb[i] = mt[i];
                        end else if (tick) begin
                            if (mt[i] == maxv(i)) ph[i] = P_RES;
                            else mt[i] = mt[i] + 1;
                        end
                    end
                    default: begin
                        if (se) begin
                            ph[i] = P_ARM;
                            mt[i] = 0;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("a_en",    en_a,  ph[0] == P_ARM);
            chk("a_led",   led_a, ph[0] == P_TIM);
            chk("a_valid", val_a, ph[0] == P_RES);
            chk("a_foul",  fs_a,  ph[0] == P_FOUL);
            chk("a_time",  tm_a,  mt[0]);
            chk("b_en",    en_b,  ph[1] == P_ARM);
            chk("b_led",   led_b, ph[1] == P_TIM);
            chk("b_valid", val_b, ph[1] == P_RES);
            chk("b_foul",  fs_b,  ph[1] == P_FOUL);
            chk("b_time",  tm_b,  mt[1]);
`ifdef BEST_TIME_EN
            chk("a_best",  best_a, mb[0]);
            chk("b_best",  best_b, mb[1]);
`endif
        end
    end

    task automatic cyc(input logic r, input logic s, input logic rc, input logic d, input logic t);
        @(negedge clk);
        rst = r; start = s; react = rc; done = d; tick = t;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(0, 0, 0, 0, 1);
            cyc(0, 0, 0, 0, 0);
        end
    endtask

    task automatic play_round(input int n);
        cyc(0, 1, 0, 0, 0);
        idle(2);
        cyc(0, 0, 0, 1, 0);
        idle(1);
        ticks(n);
        cyc(0, 0, 1, 0, 0);
        idle(1);
    endtask

    initial begin
        // Reset held for 3 cycles.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        idle(1);
        chk("lit_rst_en", en_a, 0);
        chk("lit_rst_led", led_a, 0);
        chk("lit_rst_valid", val_a, 0);
        chk("lit_rst_foul", fs_a, 0);
        chk("lit_rst_time", tm_a, 0);

        // Normal round: 37 ticks then React; small instance times out at 5.
        cyc(0, 1, 0, 0, 0);
        idle(1);
        chk("lit_armed_en", en_a, 1);
        idle(18);
        cyc(0, 0, 0, 1, 0);
        idle(1);
        chk("lit_led_on", led_a, 1);
        chk("lit_en_off", en_a, 0);
        ticks(37);
        cyc(0, 0, 1, 0, 0);
        idle(1);
        chk("lit_time37", tm_a, 37);
        chk("lit_valid37", val_a, 1);
        chk("lit_led_off", led_a, 0);
        chk("lit_timeout_time", tm_b, 5);
        chk("lit_timeout_valid", val_b, 1);

        // False start: React edge together with DelayDone.
        cyc(0, 1, 0, 0, 0);
        idle(5);
        cyc(0, 0, 1, 1, 0);
        idle(1);
        chk("lit_foul", fs_a, 1);
        chk("lit_foul_en", en_a, 0);
        chk("lit_foul_led", led_a, 0);
        chk("lit_foul_valid", val_a, 0);
        chk("lit_foul_time", tm_a, 0);

        // Reset mid-TIMING.
        cyc(0, 1, 0, 0, 0);
        idle(1);
        cyc(0, 0, 0, 1, 0);
        idle(1);
        ticks(12);
        chk("lit_time12", tm_a, 12);
        chk("lit_led12", led_a, 1);
        cyc(1, 0, 0, 0, 0);
        idle(1);
        chk("lit_abort_time", tm_a, 0);
        chk("lit_abort_led", led_a, 0);
        chk("lit_abort_en", en_a, 0);

        // Best-time tracking over 40, 25, 30, then a foul.
        play_round(40);
        chk("lit_r40", tm_a, 40);
`ifdef BEST_TIME_EN
        chk("lit_best40", best_a, 40);
`endif
        play_round(25);
        chk("lit_r25", tm_a, 25);
`ifdef BEST_TIME_EN
        chk("lit_best25", best_a, 25);
`endif
        play_round(30);
        chk("lit_r30", tm_a, 30);
`ifdef BEST_TIME_EN
        chk("lit_best25b", best_a, 25);
`endif
        cyc(0, 1, 0, 0, 0);
        idle(2);
        cyc(0, 0, 1, 0, 0);
        idle(1);
        chk("lit_foul2", fs_a, 1);
`ifdef BEST_TIME_EN
        chk("lit_best_foul", best_a, 25);
`endif

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            cyc($urandom_range(0, 599) == 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 24) == 0,
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 2) == 0);
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
